ifetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues in-order requests to instruction memory and pairs each response with its PC.
- Buffers up to DEPTH fetched instructions for decode.
- Drives the PC advance enable and discards stale fetches on any control-flow redirect (jal/jalr, taken branch, trap/set).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 74 +++++++
 rtl/ifetch_queue.sv | 131 +++++++++++++
 tb/tb_ifetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-fetch front end.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int IFQ_DEPTH = 4;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // One fetched instruction paired with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO: power-of-two depth, synchronous clear,
// occupancy count, push accepted when full only if a pop happens
// in the same cycle. Read data is the current head (first-word fall-through).
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push,  do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; clear overrides push and pop.
  always_comb begin
    do_push  = push_i & (~full_o | pop_i);
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, so clearing it would buy nothing.
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : ifq_fifo

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues in-order fetches at the current PC,
// pairs each response with its address, buffers results for decode and
// discards everything fetched before a control-flow redirect.
module ifetch_queue #(
  parameter int DEPTH = cpu_pkg::IFQ_DEPTH,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  // Queue / in-flight bookkeeping
  logic [CW-1:0]   occ;          // entries waiting for decode
  logic [CW-1:0]   infl;         // accepted, unanswered requests
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   live;         // in-flight requests whose data will be kept
  logic [CW:0]     credit_sum;
  logic            addr_full, addr_empty;
  logic            q_full, q_empty;
  logic [XLEN-1:0] rsp_addr;
  logic [EW-1:0]   q_wdata, q_rdata;
  logic [EW-1:0]   shown_q;      // last entry presented to decode
  logic [EW-1:0]   head;
  logic            accept, keep, deq, can_issue;

  // Request issue: one credit per queue slot, shared by queued entries and
  // live in-flight fetches. Stale in-flight fetches still hold an address
  // FIFO slot, so a full address FIFO also blocks issue.
  always_comb begin
    live           = infl - drop_q;
    credit_sum     = {1'b0, occ} + {1'b0, live};
    can_issue      = (credit_sum < (CW+1)'(DEPTH)) & ~addr_full;
    imem_req_valid = rst & ~flush & can_issue;
    imem_req_addr  = pc_addr;
    accept         = imem_req_valid & imem_req_ready;
    pc_en          = accept;
  end

  // Response routing and decode handshake.
  always_comb begin
    keep     = imem_rsp_valid & (drop_q == '0) & ~flush;
    q_wdata  = {imem_rsp_data, rsp_addr};
    id_valid = rst & ~q_empty;
    deq      = id_valid & id_ready & ~flush;
    head     = id_valid ? q_rdata : shown_q;
    id_inst  = rst ? head[EW-1 -: XLEN] : '0;
    id_pc    = rst ? head[XLEN-1:0]     : '0;
  end

  // Drop counter: a redirect marks every request still outstanding after
  // this cycle as stale; afterwards each response retires one stale request.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = infl - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  // Drop counter and held decode output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q  <= '0;
      shown_q <= '0;
    end else begin
      drop_q <= drop_d;
      if (id_valid) shown_q <= q_rdata;
    end
  end

  // Addresses of accepted requests, popped in order as responses return.
  ifq_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .push_i  (accept),
    .pop_i   (imem_rsp_valid),
    .wdata_i (pc_addr),
    .rdata_o (rsp_addr),
    .full_o  (addr_full),
    .empty_o (addr_empty),
    .count_o (infl)
  );

  // Fetched {inst, pc} entries waiting for decode.
  ifq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (keep),
    .pop_i   (deq),
    .wdata_i (q_wdata),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occ)
  );

  // Memory must never answer a request that was not issued.
  a_rsp_has_request : assert property (
    @(posedge clk) disable iff (!rst) !(imem_rsp_valid && addr_empty)
  );

  // Credit accounting guarantees a kept response always finds room.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst) !(keep && q_full && !deq)
  );

endmodule : ifetch_queue

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a PC register and an in-order
// instruction memory surround the DUT; a queue-based reference model
// predicts every output each cycle.
module tb_ifetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = IFQ_DEPTH;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  ifetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .pc_addr        (pc_addr),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus knobs for the current cycle
  bit          rst_v, fl_v, rr_v, idr_v;
  logic [31:0] fl_tgt;
  int          lat_min, lat_max;

  // Environment: PC register and in-order memory
  logic [31:0] pc;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];

  // Reference model: queued entries and in-flight requests with stale flag
  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  infl_t        mi[$];
  fetch_entry_t mq[$];
  fetch_entry_t last;

  int n_cmp, n_bad, cyc;
  int first_acc, first_val;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return INST_NOP ^ {a[24:0], 7'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model after posedge.
  task automatic step();
    bit           rsp_now, exp_rv, exp_iv, dut_acc, dut_pcen;
    int           live;
    fetch_entry_t exp_head;
    infl_t        e;
    logic [31:0]  acc_addr;

    rst            = rst_v;
    flush          = fl_v;
    imem_req_ready = rr_v;
    id_ready       = idr_v;
    pc_addr        = pc;
    rsp_now        = rst_v && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? inst_of(mem_q[0].addr) : 32'h0;

    @(negedge clk);
    live = 0;
    foreach (mi[i]) if (!mi[i].stale) live++;
    exp_rv   = rst_v && !fl_v && (mq.size() + live < DEPTH) && (mi.size() < DEPTH);
    exp_iv   = rst_v && (mq.size() > 0);
    exp_head = !rst_v ? '0 : (exp_iv ? mq[0] : last);

    check("req_valid", imem_req_valid, exp_rv);
    check("pc_en",     pc_en,          exp_rv && rr_v);
    check("id_valid",  id_valid,       exp_iv);
    check("id_inst",   id_inst,        exp_head.inst);
    check("id_pc",     id_pc,          exp_head.pc);
    if (exp_rv) check("req_addr", imem_req_addr, pc);

    dut_acc  = imem_req_valid && imem_req_ready;
    dut_pcen = pc_en;
    acc_addr = imem_req_addr;
    if (exp_rv && rr_v && first_acc < 0) first_acc = cyc;
    if (id_valid && first_val < 0) first_val = cyc;

    @(posedge clk);
    #1;
    if (!rst_v) begin
      mq.delete();
      mi.delete();
      mem_q.delete();
      last = '0;
      pc   = 32'h0;
    end else begin
      if (exp_iv) last = mq[0];
      if (fl_v) mq.delete();
      else if (exp_iv && idr_v) void'(mq.pop_front());
      if (rsp_now) begin
        void'(mem_q.pop_front());
        check("rsp_infl_empty", mi.size() == 0, 1'b0);
        if (mi.size() > 0) begin
          e = mi.pop_front();
          if (!e.stale && !fl_v) mq.push_back('{inst: inst_of(e.addr), pc: e.addr});
        end
      end
      if (fl_v) foreach (mi[i]) mi[i].stale = 1'b1;
      if (exp_rv && rr_v) mi.push_back('{addr: pc, stale: 1'b0});
      if (dut_acc)
        mem_q.push_back('{addr: acc_addr,
                          due: cyc + lat_min + int'($urandom_range(lat_max - lat_min))});
      if (fl_v) pc = fl_tgt;
      else if (dut_pcen) pc = pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    bit          pat [4];
    logic [31:0] pc_stall;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_cmp = 0; n_bad = 0; cyc = 0;
    first_acc = -1; first_val = -1;
    pc = 32'h0; last = '0; fl_tgt = 32'h0;
    rst_v = 1'b0; fl_v = 1'b0; rr_v = 1'b1; idr_v = 1'b1;
    lat_min = 1; lat_max = 1;

    // Reset
    repeat (3) step();

    // Streaming at latency 1, then a redirect while a response and a pop land
    rst_v = 1'b1;
    first_acc = -1; first_val = -1;
    repeat (20) step();
    check("first_valid_latency", first_val - first_acc, 32'd2);
    fl_v = 1'b1; fl_tgt = 32'h100;
    step();
    fl_v = 1'b0;
    repeat (10) step();

    // Decode stall fills the queue and freezes the PC, then drains
    idr_v = 1'b0;
    repeat (10) step();
    pc_stall = pc;
    repeat (5) step();
    check("pc_frozen", pc, pc_stall);
    idr_v = 1'b1;
    repeat (15) step();

    // Two fetches in flight at 0x10/0x14, redirected to 0x100
    lat_min = 3; lat_max = 3;
    fl_v = 1'b1; fl_tgt = 32'h10;
    step();
    fl_v = 1'b0;
    repeat (2) step();
    fl_v = 1'b1; fl_tgt = 32'h100;
    step();
    fl_v = 1'b0;
    repeat (12) step();

    // Memory ready toggling 1,0,0,1 at latency 3
    for (int i = 0; i < 24; i++) begin
      rr_v = pat[i % 4];
      step();
    end
    rr_v = 1'b1;

    // Reset with work queued and in flight
    idr_v = 1'b0;
    repeat (3) step();
    rst_v = 1'b0;
    step();
    rst_v = 1'b1; idr_v = 1'b1; lat_min = 1; lat_max = 1;
    repeat (10) step();

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      rr_v   = ($urandom_range(3) != 0);
      idr_v  = ($urandom_range(9) < 6);
      fl_v   = ($urandom_range(19) == 0);
      fl_tgt = $urandom & 32'hFFFF_FFFC;
      rst_v  = ($urandom_range(99) != 0);
      step();
    end
    rst_v = 1'b1; fl_v = 1'b0; rr_v = 1'b1; idr_v = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ifetch_queue
